atcaxi2tluh500_cdc_hsk_src: RTL and testbench



---
 rtl/atcaxi2tluh500_cdc_hsk_src.sv | 165 ++++++++++++++++
 tb/tb_atcaxi2tluh500_cdc_hsk_src.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atcaxi2tluh500_cdc_hsk_src.sv
// Source side of a four-phase req/ack handshake that carries a held payload across clock domains.
// Optional handshake timeout flag is built when ATCAXI2TLUH500_HSK_TIMEOUT_EN is defined.

module atcaxi2tluh500_sync_l2l #(
  parameter int unsigned STAGES      = 2,
  parameter logic        RESET_VALUE = 1'b0
) (
  input  logic clk,
  input  logic resetn,
  input  logic data_i,
  output logic data_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= {STAGES{RESET_VALUE}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], data_i};
    end
  end

  assign data_o = sync_q[STAGES-1];

endmodule

module atcaxi2tluh500_cdc_hsk_src #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned SYNC_STAGE     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  hsk_req,
  output logic [DATA_WIDTH-1:0] hsk_data,
  input  logic                  hsk_ack,
  output logic                  busy,
  output logic                  done,
  input  logic                  timeout_clr,
  output logic                  hsk_timeout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  done_q, done_d;
  logic                  ack_s;
  logic                  accept_c;

  atcaxi2tluh500_sync_l2l #(
    .STAGES      (SYNC_STAGE),
    .RESET_VALUE (1'b0)
  ) u_ack_sync (
    .clk    (clk),
    .resetn (resetn),
    .data_i (hsk_ack),
    .data_o (ack_s)
  );

  // A stale ack in IDLE blocks acceptance until the destination has released it.
  assign accept_c = (state_q == IDLE) && in_valid && !ack_s;

  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    data_d   = data_q;
    done_d   = 1'b0;
    in_ready = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = !ack_s;
        if (accept_c) begin
          data_d  = in_data;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (ack_s) begin
          req_d   = 1'b0;
          state_d = REL;
        end
      end
      REL: begin
        if (!ack_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  assign hsk_req  = req_q;
  assign hsk_data = data_q;
  assign done     = done_q;
  assign busy     = (state_q != IDLE);

`ifdef ATCAXI2TLUH500_HSK_TIMEOUT_EN
  localparam int unsigned      CNT_W     = 16;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             timeout_q, timeout_d;
  logic             timeout_set_c;

  // Saturating cycle count of the current handshake, restarted at acceptance.
  always_comb begin
    cnt_d = cnt_q;
    if (accept_c) begin
      cnt_d = '0;
    end else if ((state_q != IDLE) && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign timeout_set_c = (state_q != IDLE) && (cnt_d == CNT_LIMIT);
  assign timeout_d     = timeout_set_c | (timeout_q & ~timeout_clr);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign hsk_timeout = timeout_q;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = timeout_clr | (TIMEOUT_CYCLES == 32'd0);
  assign hsk_timeout        = 1'b0;
`endif

endmodule

// File: tb/tb_atcaxi2tluh500_cdc_hsk_src.sv
// Self-checking bench for the handshake source: vector table, scoreboarded traffic and corner sequences.
module tb_atcaxi2tluh500_cdc_hsk_src;

  localparam int unsigned DW   = 32;
  localparam int unsigned SYNC = 2;
  localparam int unsigned TO   = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          hsk_req;
  logic [DW-1:0] hsk_data;
  logic          hsk_ack;
  logic          busy;
  logic          done;
  logic          timeout_clr;
  logic          hsk_timeout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] cur_data;
  int            ack_rise_cyc;
  int            ack_fall_cyc;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
    logic          a;
    logic          rdy;
    logic          req;
    logic [DW-1:0] dat;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t vecs[13];

  atcaxi2tluh500_cdc_hsk_src #(
    .DATA_WIDTH     (DW),
    .SYNC_STAGE     (SYNC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .hsk_req     (hsk_req),
    .hsk_data    (hsk_data),
    .hsk_ack     (hsk_ack),
    .busy        (busy),
    .done        (done),
    .timeout_clr (timeout_clr),
    .hsk_timeout (hsk_timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got stuck want finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    #2;
  endtask

  task automatic do_reset(input logic ack_level);
    resetn      = 1'b0;
    in_valid    = 1'b0;
    in_data     = '0;
    hsk_ack     = ack_level;
    timeout_clr = 1'b0;
    cur_data    = '0;
    exp_q.delete();
    tick();
    tick();
    chk("rst_req", hsk_req, 0);
    chk("rst_data", hsk_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", hsk_timeout, 0);
    resetn = 1'b1;
  endtask

  // Producer drains src_q with valid/ready; destination answers req with a (random) delay.
  task automatic run_traffic(input int max_cycles, input bit rnd);
    int   dcnt;
    int   n;
    bit   acc;
    bit   req_prev;
    bit   done_prev;
    logic [DW-1:0] acc_data;
    dcnt      = 2;
    n         = 0;
    req_prev  = 1'b0;
    done_prev = 1'b0;
    while ((src_q.size() > 0 || exp_q.size() > 0 || in_valid || busy) && n < max_cycles) begin
      if (!in_valid && src_q.size() > 0 && (!rnd || ($urandom_range(0, 1) == 1))) begin
        in_valid = 1'b1;
        in_data  = src_q.pop_front();
      end else if (!in_valid && rnd) begin
        in_data = $urandom;
      end
      #1;
      acc      = in_valid && in_ready;
      acc_data = in_data;
      tick();
      n++;
      if (acc) begin
        chk("acc_req_rise", hsk_req, 1);
        chk("acc_data", hsk_data, acc_data);
        chk("acc_busy", busy, 1);
        exp_q.push_back(acc_data);
        cur_data = acc_data;
        in_valid = 1'b0;
      end
      chk("data_hold", hsk_data, cur_data);
      if (busy) chk("ready_while_busy", in_ready, 0);
      if (req_prev && !hsk_req) chk("req_fall_lat", DW'(cyc - ack_rise_cyc), DW'(SYNC + 1));
      if (done) begin
        chk("done_lat", DW'(cyc - ack_fall_cyc), DW'(SYNC + 1));
        chk("done_single", done_prev, 0);
        chk("done_idle", busy, 0);
        chk("ready_at_done", in_ready, 1);
        chk("done_has_xfer", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      end
      if (hsk_req && !hsk_ack) begin
        if (dcnt == 0) begin
          hsk_ack      = 1'b1;
          ack_rise_cyc = cyc;
          dcnt         = rnd ? int'($urandom_range(0, 3)) : 2;
        end else dcnt--;
      end else if (!hsk_req && hsk_ack) begin
        if (dcnt == 0) begin
          hsk_ack      = 1'b0;
          ack_fall_cyc = cyc;
          dcnt         = rnd ? int'($urandom_range(0, 3)) : 2;
        end else dcnt--;
      end
      req_prev  = hsk_req;
      done_prev = done;
    end
    if (n >= max_cycles) chk("traffic_budget", 1, 0);
    chk("traffic_drained", DW'(exp_q.size()), 0);
  endtask

  task automatic wait_for(input string name, input bit which, input int budget);
    int n;
    n = 0;
    while (((which == 1'b0) ? hsk_req : !done) && n < budget) begin
      tick();
      n++;
    end
    chk(name, n < budget, 1);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 32'hA5A5_0001, 1'b0, 1'b1, 1'b1, 32'hA5A5_0001, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 32'hA5A5_0001, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 32'h0,         1'b0, 1'b1, 1'b0, 32'hA5A5_0001, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 32'h0BAD_F00D, 1'b0, 1'b1, 1'b1, 32'h0BAD_F00D, 1'b1, 1'b0};

    // Single transfer, cycle by cycle.
    do_reset(1'b0);
    chk("rst_ready", in_ready, 1);
    for (int i = 0; i < 13; i++) begin
      in_valid = vecs[i].v;
      in_data  = vecs[i].d;
      hsk_ack  = vecs[i].a;
      #1;
      chk("vec_ready", in_ready, vecs[i].rdy);
      tick();
      chk("vec_req", hsk_req, vecs[i].req);
      chk("vec_data", hsk_data, vecs[i].dat);
      chk("vec_busy", busy, vecs[i].busy);
      chk("vec_done", done, vecs[i].done);
    end

    // Back-to-back payloads with valid held.
    do_reset(1'b0);
    src_q = '{32'd1, 32'd2, 32'd3};
    run_traffic(200, 1'b0);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 40; i++) src_q.push_back($urandom);
    run_traffic(3000, 1'b1);

    // Stale ack across reset release.
    do_reset(1'b1);
    tick();
    tick();
    tick();
    chk("stale_ready", in_ready, 0);
    in_valid = 1'b1;
    in_data  = 32'h0000_0005;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stale_ready_hold", in_ready, 0);
      chk("stale_no_req", hsk_req, 0);
    end
    hsk_ack = 1'b0;
    tick();
    chk("stale_ready_1cyc", in_ready, 0);
    tick();
    chk("stale_release", in_ready, 1);
    tick();
    chk("stale_accept_req", hsk_req, 1);
    chk("stale_accept_data", hsk_data, 32'h0000_0005);
    in_valid = 1'b0;

    // Asynchronous reset in the middle of REQ.
    #1;
    resetn = 1'b0;
    #1;
    chk("midrst_req", hsk_req, 0);
    chk("midrst_data", hsk_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    tick();
    resetn   = 1'b1;
    cur_data = '0;
    tick();
    src_q = '{32'h0000_00FF};
    run_traffic(100, 1'b0);

    // Stalled destination: timeout flag behaviour.
    do_reset(1'b0);
    in_valid = 1'b1;
    in_data  = 32'hC0DE_0008;
    tick();
    in_valid = 1'b0;
    chk("to_req", hsk_req, 1);
`ifdef ATCAXI2TLUH500_HSK_TIMEOUT_EN
    for (int i = 0; i < 7; i++) tick();
    chk("to_before", hsk_timeout, 0);
    tick();
    chk("to_set", hsk_timeout, 1);
    chk("to_req_held", hsk_req, 1);
    for (int i = 0; i < 5; i++) tick();
    chk("to_sticky", hsk_timeout, 1);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    chk("to_clear", hsk_timeout, 0);
`else
    for (int i = 0; i < 100; i++) begin
      if (i == 50) timeout_clr = 1'b1;
      if (i == 51) timeout_clr = 1'b0;
      tick();
      chk("to_off", hsk_timeout, 0);
    end
    chk("to_req_held", hsk_req, 1);
`endif
    hsk_ack = 1'b1;
    wait_for("to_req_fall", 1'b0, 10);
    hsk_ack = 1'b0;
    wait_for("to_done", 1'b1, 10);
    chk("to_done_data", hsk_data, 32'hC0DE_0008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
